// File: rtl/pipe_stall_ctrl.sv
// Hazard, flush, freeze and halt control for a 5-stage in-order pipe; stall outputs are same-cycle combinational.
// Optional build macro STALL_CNT_EN adds a saturating 16-bit stall-cycle counter.
module pipe_stall_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic [3:0]  id_rd,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        id_rd_used,
  input  logic        id_wr,
  input  logic        id_valid,
  input  logic        id_hlt,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        pipe_freeze,
  output logic        hazard,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t state_q;
  logic   halted_q;

  // Writer shadow: one {wr, rd} record per downstream stage.
  logic       ex_wr_q,  mem_wr_q,  wb_wr_q;
  logic [3:0] ex_rd_q,  mem_rd_q,  wb_rd_q;
  logic       ex_wr_d,  mem_wr_d,  wb_wr_d;
  logic [3:0] ex_rd_d,  mem_rd_d,  wb_rd_d;

  function automatic logic slot_hit(
    input logic       wr,
    input logic [3:0] rd,
    input logic [3:0] rs,
    input logic [3:0] rt,
    input logic [3:0] rdf,
    input logic       rs_u,
    input logic       rt_u,
    input logic       rd_u
  );
    return wr && (rd != 4'd0) &&
           ((rs_u && (rs == rd)) || (rt_u && (rt == rd)) || (rd_u && (rdf == rd)));
  endfunction

  assign hazard = id_valid &&
    (slot_hit(ex_wr_q,  ex_rd_q,  id_rs, id_rt, id_rd, id_rs_used, id_rt_used, id_rd_used) ||
     slot_hit(mem_wr_q, mem_rd_q, id_rs, id_rt, id_rd, id_rs_used, id_rt_used, id_rd_used) ||
     slot_hit(wb_wr_q,  wb_rd_q,  id_rs, id_rt, id_rd, id_rs_used, id_rt_used, id_rd_used));

  // Priority: memory freeze, then halt hold, then branch flush, then drain/hazard hold.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (state_q == ST_HALT) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (br_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if ((state_q == ST_DRAIN) || hazard) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    ex_wr_d  = ex_wr_q;
    ex_rd_d  = ex_rd_q;
    mem_wr_d = mem_wr_q;
    mem_rd_d = mem_rd_q;
    wb_wr_d  = wb_wr_q;
    wb_rd_d  = wb_rd_q;
    if (!mem_busy) begin
      ex_wr_d  = !id_ex_bubble && id_wr && id_valid;
      ex_rd_d  = id_ex_bubble ? 4'd0 : id_rd;
      mem_wr_d = ex_wr_q;
      mem_rd_d = ex_rd_q;
      wb_wr_d  = mem_wr_q;
      wb_rd_d  = mem_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_wr_q  <= 1'b0;
      ex_rd_q  <= 4'd0;
      mem_wr_q <= 1'b0;
      mem_rd_q <= 4'd0;
      wb_wr_q  <= 1'b0;
      wb_rd_q  <= 4'd0;
    end else begin
      ex_wr_q  <= ex_wr_d;
      ex_rd_q  <= ex_rd_d;
      mem_wr_q <= mem_wr_d;
      mem_rd_q <= mem_rd_d;
      wb_wr_q  <= wb_wr_d;
      wb_rd_q  <= wb_rd_d;
    end
  end

  // Drain completes once no writer remains after this cycle's shift (EX refills with a bubble).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else if (!mem_busy) begin
      case (state_q)
        ST_RUN: begin
          if (id_hlt && id_valid && !hazard && !br_taken)
            state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (br_taken) begin
            state_q <= ST_RUN;
          end else if (!ex_wr_q && !mem_wr_q) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign halted = halted_q;

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= 16'h0000;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule
